// File: rtl/hamming_pkg.sv
// Shared helpers for the streaming Hamming encoder: parity-count sizing,
// data-bit placement and per-parity-bit coverage masks.
package hamming_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_PAR_W  = 5;
    localparam int DEF_CW_W   = 21;

    // Smallest P such that 2**P >= K+P+1.
    function automatic int par_w(input int k);
        int p;
        p = 1;
        for (int i = 0; i < 8; i++) begin
            if ((1 << p) < (k + p + 1)) p++;
        end
        return p;
    endfunction

    function automatic bit is_pow2(input int i);
        return (i > 0) && ((i & (i - 1)) == 0);
    endfunction

    // Hamming position (1-based) of data bit idx, skipping power-of-two slots.
    function automatic int data_pos(input int idx);
        int pos;
        int seen;
        pos  = 0;
        seen = 0;
        for (int p = 3; p < 128; p++) begin
            if (!is_pow2(p) && (pos == 0)) begin
                if (seen == idx) pos = p;
                seen++;
            end
        end
        return pos;
    endfunction

    function automatic logic [63:0] par_mask(input int k, input int j);
        logic [63:0] mask;
        mask = '0;
        for (int i = 0; i < k; i++) begin
            if (((data_pos(i) >> j) & 1) == 1) mask[i] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/hamming_encode_comb.sv
// Pure combinational Hamming(N,K) encoder with optional SECDED overall parity MSB.
// Also used as a golden model by the decoder bench.
module hamming_encode_comb
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int SECDED = 0,
    localparam int PAR_W  = par_w(DATA_W),
    localparam int N_W    = DATA_W + PAR_W,
    localparam int CW_W   = N_W + SECDED
) (
    input  logic [DATA_W-1:0] data_i,
    output logic [CW_W-1:0]   code_o
);

    logic [N_W-1:0] ham;

    genvar i, j;
    generate
        for (i = 0; i < DATA_W; i++) begin : g_data
            assign ham[data_pos(i)-1] = data_i[i];
        end

        // Parity at position 2**j covers every data position with bit j set.
        for (j = 0; j < PAR_W; j++) begin : g_par
            localparam logic [DATA_W-1:0] MASK = DATA_W'(par_mask(DATA_W, j));
            assign ham[(1 << j)-1] = ^(data_i & MASK);
        end

        if (SECDED != 0) begin : g_secded
            assign code_o = {^ham, ham};
        end else begin : g_plain
            assign code_o = ham;
        end
    endgenerate

endmodule

// File: rtl/hamming_encoder_stream.sv
// Streaming Hamming encoder: valid/ready input, encode, 2-entry registered FIFO,
// valid/ready output and a wrapping count of delivered codewords.
module hamming_encoder_stream
    import hamming_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int SECDED = 0,
    parameter  int CNT_W  = 16,
    localparam int PAR_W  = par_w(DATA_W),
    localparam int CW_W   = DATA_W + PAR_W + SECDED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW_W-1:0]   out_code,
    output logic [CNT_W-1:0]  out_cnt
);

    logic [CW_W-1:0]  encCode;
    logic [CW_W-1:0]  mem0_q, mem1_q;
    logic             wrPtr_q, rdPtr_q;
    logic [1:0]       count_q, count_d;
    logic             full_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push, pop;

    hamming_encode_comb #(
        .DATA_W (DATA_W),
        .SECDED (SECDED)
    ) u_encode (
        .data_i (in_data),
        .code_o (encCode)
    );

    // Full flag is registered so out_ready never reaches in_ready combinationally.
    assign in_ready  = !rst && !full_q;
    assign push      = in_valid && in_ready;
    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_code  = out_valid ? (rdPtr_q ? mem1_q : mem0_q) : '0;
    assign out_cnt   = cnt_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem0_q  <= '0;
            mem1_q  <= '0;
            wrPtr_q <= 1'b0;
            rdPtr_q <= 1'b0;
            count_q <= 2'd0;
            full_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (push) begin
                if (wrPtr_q) mem1_q <= encCode;
                else         mem0_q <= encCode;
                wrPtr_q <= !wrPtr_q;
            end
            if (pop) begin
                rdPtr_q <= !rdPtr_q;
                cnt_q   <= cnt_q + CNT_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == 2'd2);
        end
    end

endmodule
